// File: rtl/apb_timer_slave.sv
// APB3 timer slave: one 16-byte register window, prescaled down-counter with
// periodic/one-shot reload, level interrupt and programmable wait states.
module apb_timer_slave #(
    parameter int ADDRWIDTH   = 16,
    parameter int DATAWIDTH   = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 PCLKEN,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic                 PWRITE,
    input  logic [ADDRWIDTH-1:0] PADDR,
    input  logic [DATAWIDTH-1:0] PWDATA,
    output logic [DATAWIDTH-1:0] PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR,
    output logic                 IRQ
);
    localparam logic [3:0] WAIT_LIM = 4'(WAIT_STATES);

    // The setup phase is consumed on the edge into ACCESS, so a zero-wait
    // transfer completes in its first access-phase cycle.
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t               state, state_next;
    logic [3:0]           wcnt, wcnt_next;
    logic                 capture, ready;
    logic [1:0]           lat_reg;
    logic                 lat_write, lat_err;
    logic [DATAWIDTH-1:0] lat_wdata;

    logic                 en, irqen, oneshot, intstat;
    logic [7:0]           prescale, presc;
    logic [DATAWIDTH-1:0] reload, value, rd_mux;
    logic                 wr_en, ctrl_wr, reload_wr, value_wr, int_wr;
    logic                 run, tick, expire;
    logic                 addr_unused;

    assign addr_unused = ^PADDR[1:0];

    always_comb begin
        state_next = state;
        wcnt_next  = wcnt;
        capture    = 1'b0;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    capture    = 1'b1;
                    wcnt_next  = '0;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_next = IDLE;
                end else if (wcnt < WAIT_LIM) begin
                    wcnt_next = wcnt + 4'd1;
                end else begin
                    ready = 1'b1;
                    if (!PENABLE) begin
                        capture    = 1'b1;
                        wcnt_next  = '0;
                        state_next = ACCESS;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state     <= IDLE;
            wcnt      <= '0;
            lat_reg   <= '0;
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
            lat_wdata <= '0;
        end else if (PCLKEN) begin
            state <= state_next;
            wcnt  <= wcnt_next;
            if (capture) begin
                lat_reg   <= PADDR[3:2];
                lat_write <= PWRITE;
                lat_err   <= |PADDR[ADDRWIDTH-1:4];
                lat_wdata <= PWDATA;
            end
        end
    end

    assign wr_en     = PCLKEN && ready && lat_write && !lat_err;
    assign ctrl_wr   = wr_en && (lat_reg == 2'd0);
    assign reload_wr = wr_en && (lat_reg == 2'd1);
    assign value_wr  = wr_en && (lat_reg == 2'd2);
    assign int_wr    = wr_en && (lat_reg == 2'd3);

    // A CTRL write that clears EN suppresses the tick of that same cycle.
    assign run    = PCLKEN && en && !(ctrl_wr && !lat_wdata[0]);
    assign tick   = run && (presc == prescale);
    assign expire = tick && (value == '0);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            en       <= 1'b0;
            irqen    <= 1'b0;
            oneshot  <= 1'b0;
            prescale <= '0;
            presc    <= '0;
            reload   <= '0;
            value    <= '0;
            intstat  <= 1'b0;
        end else begin
            if (ctrl_wr && lat_wdata[0] && !en)
                presc <= '0;
            else if (run)
                presc <= tick ? 8'd0 : presc + 8'd1;

            if (ctrl_wr) begin
                en       <= lat_wdata[0];
                irqen    <= lat_wdata[1];
                oneshot  <= lat_wdata[2];
                prescale <= lat_wdata[15:8];
            end else if (expire && oneshot) begin
                en <= 1'b0;
            end

            if (reload_wr)
                reload <= lat_wdata;

            if (value_wr)
                value <= lat_wdata;
            else if (expire && !oneshot)
                value <= reload;
            else if (tick && !expire)
                value <= value - DATAWIDTH'(1);

            if (expire)
                intstat <= 1'b1;
            else if (int_wr && lat_wdata[0])
                intstat <= 1'b0;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (lat_reg)
            2'd0: begin
                rd_mux[0]    = en;
                rd_mux[1]    = irqen;
                rd_mux[2]    = oneshot;
                rd_mux[15:8] = prescale;
            end
            2'd1:    rd_mux = reload;
            2'd2:    rd_mux = value;
            default: rd_mux[0] = intstat;
        endcase
    end

    assign PREADY  = ready;
    assign PSLVERR = ready && lat_err;
    assign PRDATA  = (ready && !lat_write && !lat_err) ? rd_mux : '0;
    assign IRQ     = intstat && irqen;

endmodule

// File: tb/tb_apb_timer_slave.sv
// Self-checking bench for apb_timer_slave: directed scenarios plus randomized
// traffic, checked against a transaction-level timer model.
module tb_apb_timer_slave;
    localparam int WS = 2;

    logic        HCLK = 1'b0;
    logic        HRESET, PCLKEN, PSEL, PENABLE, PWRITE;
    logic [15:0] PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR, IRQ;

    int vectors = 0;
    int miscompares = 0;
    bit gap_en = 1'b0;

    // reference model state
    bit          m_en, m_irqen, m_oneshot, m_intstat;
    logic [7:0]  m_prescale;
    int          m_presc;
    logic [31:0] m_reload, m_value;

    always #5 HCLK = ~HCLK;

    apb_timer_slave #(.ADDRWIDTH(16), .DATAWIDTH(32), .WAIT_STATES(WS)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .PCLKEN(PCLKEN), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .IRQ(IRQ)
    );

    task automatic m_reset();
        m_en = 0; m_irqen = 0; m_oneshot = 0; m_intstat = 0;
        m_prescale = '0; m_presc = 0; m_reload = '0; m_value = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] r);
        case (r)
            2'd0:    return {16'h0, m_prescale, 5'h0, m_oneshot, m_irqen, m_en};
            2'd1:    return m_reload;
            2'd2:    return m_value;
            default: return {31'h0, m_intstat};
        endcase
    endfunction

    // One enabled APB clock of the timer, with an optional committing write.
    task automatic m_step(input bit pe, input bit wr, input logic [1:0] r, input logic [31:0] d);
        bit tick, set_now, en_old;
        if (!pe) return;
        tick = 0; set_now = 0; en_old = m_en;
        if (m_en && !(wr && r == 2'd0 && !d[0])) begin
            if (m_presc == int'(m_prescale)) begin tick = 1; m_presc = 0; end
            else m_presc = m_presc + 1;
        end
        if (tick) begin
            if (m_value != 0) m_value = m_value - 1;
            else begin
                set_now = 1; m_intstat = 1;
                if (m_oneshot) m_en = 0; else m_value = m_reload;
            end
        end
        if (wr) begin
            case (r)
                2'd0: begin
                    if (d[0] && !en_old) m_presc = 0;
                    m_en = d[0]; m_irqen = d[1]; m_oneshot = d[2]; m_prescale = d[15:8];
                end
                2'd1: m_reload = d;
                2'd2: m_value = d;
                default: if (d[0] && !set_now) m_intstat = 0;
            endcase
        end
    endtask

    task automatic clk_edge(input bit wr, input logic [1:0] r, input logic [31:0] d);
        bit pe;
        pe = PCLKEN;
        @(posedge HCLK);
        m_step(pe, wr, r, d);
        #1;
    endtask

    task automatic gaps();
        int n;
        if (gap_en) begin
            n = $urandom_range(0, 2);
            PCLKEN = 0;
            repeat (n) clk_edge(0, 2'd0, '0);
        end
        PCLKEN = 1;
    endtask

    task automatic apb_xfer(input bit wr, input logic [15:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output logic [31:0] ex,
                            output bit err, output int waits, output bit done);
        bit aerr, rdy;
        aerr = (a[15:4] != 12'h0);
        PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = a; PWDATA = d;
        gaps();
        clk_edge(0, 2'd0, '0);
        PENABLE = 1; waits = 0; done = 0; rd = '0; ex = '0; err = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            gaps();
            @(negedge HCLK);
            rdy = PREADY;
            if (rdy) begin
                done = 1; rd = PRDATA; err = PSLVERR;
                ex = (wr || aerr) ? 32'h0 : m_read(a[3:2]);
            end else begin
                waits++;
            end
            clk_edge(rdy && wr && !aerr, a[3:2], d);
        end
        PSEL = 0; PENABLE = 0;
        if (!done) begin
            miscompares++;
            $display("FAIL xfer_timeout addr=%h: PREADY never rose", a);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd, ex; bit err, done; int waits;
        HRESET = 1; PCLKEN = 1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
        repeat (2) @(posedge HCLK);
        #1;
        vectors++; if (PREADY !== 1'b0) begin miscompares++; $display("FAIL rst_pready: got %b exp 0", PREADY); end
        vectors++; if (PSLVERR !== 1'b0) begin miscompares++; $display("FAIL rst_pslverr: got %b exp 0", PSLVERR); end
        vectors++; if (PRDATA !== 32'h0) begin miscompares++; $display("FAIL rst_prdata: got %h exp 0", PRDATA); end
        vectors++; if (IRQ !== 1'b0) begin miscompares++; $display("FAIL rst_irq: got %b exp 0", IRQ); end
        HRESET = 0;
        m_reset();
        for (int r = 0; r < 4; r++) begin
            apb_xfer(0, 16'(r * 4), '0, rd, ex, err, waits, done);
            vectors++; if (rd !== 32'h0 || err !== 1'b0) begin miscompares++; $display("FAIL rst_read%0d: got %h err %b exp 0 err 0", r, rd, err); end
            vectors++; if (IRQ !== 1'b0) begin miscompares++; $display("FAIL rst_read_irq%0d: got %b exp 0", r, IRQ); end
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd, ex, d; bit err, done; int waits;
        gap_en = 1;
        apb_xfer(1, 16'h0004, 32'h5, rd, ex, err, waits, done);
        vectors++; if (waits !== WS || err !== 1'b0) begin miscompares++; $display("FAIL ws_write: waits %0d err %b exp %0d err 0", waits, err, WS); end
        apb_xfer(0, 16'h0004, '0, rd, ex, err, waits, done);
        vectors++; if (waits !== WS) begin miscompares++; $display("FAIL ws_read: waits %0d exp %0d", waits, WS); end
        vectors++; if (rd !== 32'h5) begin miscompares++; $display("FAIL ws_reload: got %h exp 5", rd); end
        for (int i = 0; i < 6; i++) begin
            d = $urandom;
            apb_xfer(1, (i % 2) ? 16'h0008 : 16'h0004, d, rd, ex, err, waits, done);
            apb_xfer(0, (i % 2) ? 16'h0008 : 16'h0004, '0, rd, ex, err, waits, done);
            vectors++; if (rd !== ex || rd !== d) begin miscompares++; $display("FAIL ws_rw%0d: got %h exp %h", i, rd, d); end
        end
    endtask

    task automatic test_periodic();
        logic [31:0] rd, ex; bit err, done; int waits, cnt;
        gap_en = 0;
        apb_xfer(1, 16'h000C, 32'h1, rd, ex, err, waits, done);
        apb_xfer(1, 16'h0004, 32'h5, rd, ex, err, waits, done);
        apb_xfer(1, 16'h0008, 32'h3, rd, ex, err, waits, done);
        apb_xfer(1, 16'h0000, 32'h3, rd, ex, err, waits, done);
        cnt = 0;
        while (!m_intstat && cnt < 12) begin
            vectors++; if (IRQ !== 1'b0) begin miscompares++; $display("FAIL per_irq_early: got %b exp 0 at %0d", IRQ, cnt); end
            clk_edge(0, 2'd0, '0);
            cnt++;
        end
        vectors++; if (cnt !== 4) begin miscompares++; $display("FAIL per_ticks: got %0d exp 4", cnt); end
        vectors++; if (IRQ !== 1'b1) begin miscompares++; $display("FAIL per_irq: got %b exp 1", IRQ); end
        apb_xfer(0, 16'h0008, '0, rd, ex, err, waits, done);
        vectors++; if (rd !== ex || rd !== 32'h2) begin miscompares++; $display("FAIL per_value: got %h exp %h", rd, ex); end
        apb_xfer(0, 16'h000C, '0, rd, ex, err, waits, done);
        vectors++; if (rd !== 32'h1) begin miscompares++; $display("FAIL per_intstat: got %h exp 1", rd); end
        apb_xfer(1, 16'h0000, 32'h2, rd, ex, err, waits, done);
        apb_xfer(1, 16'h000C, 32'h1, rd, ex, err, waits, done);
        vectors++; if (IRQ !== 1'b0 || IRQ !== (m_intstat & m_irqen)) begin miscompares++; $display("FAIL per_w1c_irq: got %b exp 0", IRQ); end
    endtask

    task automatic test_oneshot();
        logic [31:0] rd, ex; bit err, done; int waits;
        gap_en = 0;
        apb_xfer(1, 16'h0008, 32'h1, rd, ex, err, waits, done);
        apb_xfer(1, 16'h0000, 32'h0305, rd, ex, err, waits, done);
        apb_xfer(0, 16'h0008, '0, rd, ex, err, waits, done);
        vectors++; if (rd !== 32'h1 || rd !== ex) begin miscompares++; $display("FAIL os_value_pre: got %h exp 1", rd); end
        apb_xfer(0, 16'h000C, '0, rd, ex, err, waits, done);
        vectors++; if (rd !== 32'h0 || rd !== ex) begin miscompares++; $display("FAIL os_intstat_pre: got %h exp 0", rd); end
        apb_xfer(0, 16'h0000, '0, rd, ex, err, waits, done);
        vectors++; if (rd !== 32'h0304 || rd !== ex) begin miscompares++; $display("FAIL os_ctrl: got %h exp 00000304", rd); end
        apb_xfer(0, 16'h000C, '0, rd, ex, err, waits, done);
        vectors++; if (rd !== 32'h1) begin miscompares++; $display("FAIL os_intstat: got %h exp 1", rd); end
        repeat (8) clk_edge(0, 2'd0, '0);
        apb_xfer(0, 16'h0008, '0, rd, ex, err, waits, done);
        vectors++; if (rd !== 32'h0 || rd !== ex) begin miscompares++; $display("FAIL os_value_hold: got %h exp 0", rd); end
        vectors++; if (IRQ !== 1'b0) begin miscompares++; $display("FAIL os_irq: got %b exp 0", IRQ); end
    endtask

    task automatic test_slverr();
        logic [31:0] rd, ex; bit err, done; int waits;
        logic [15:0] a;
        gap_en = 1;
        apb_xfer(0, 16'h0010, '0, rd, ex, err, waits, done);
        vectors++; if (err !== 1'b1 || rd !== 32'h0 || waits !== WS) begin miscompares++; $display("FAIL err_read10: err %b data %h waits %0d exp 1 0 %0d", err, rd, waits, WS); end
        for (int i = 0; i < 8; i++) begin
            a = {12'($urandom_range(1, 4095)), 2'(i % 4), 2'b00};
            apb_xfer(1, a, 32'hFFFF_FFFF, rd, ex, err, waits, done);
            vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_write %h: err %b exp 1", a, err); end
        end
        for (int r = 0; r < 4; r++) begin
            apb_xfer(0, 16'(r * 4), '0, rd, ex, err, waits, done);
            vectors++; if (rd !== ex || err !== 1'b0) begin miscompares++; $display("FAIL err_untouched%0d: got %h err %b exp %h err 0", r, rd, err, ex); end
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd, ex; bit err, done; int waits;
        gap_en = 0; PCLKEN = 1;
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 16'h0004; PWDATA = 32'hDEAD_BEEF;
        clk_edge(0, 2'd0, '0);
        PENABLE = 1;
        @(negedge HCLK);
        vectors++; if (PREADY !== 1'b0) begin miscompares++; $display("FAIL abort_pready: got %b exp 0", PREADY); end
        clk_edge(0, 2'd0, '0);
        PSEL = 0; PENABLE = 0;
        repeat (3) clk_edge(0, 2'd0, '0);
        apb_xfer(0, 16'h0004, '0, rd, ex, err, waits, done);
        vectors++; if (rd !== ex) begin miscompares++; $display("FAIL abort_reload: got %h exp %h", rd, ex); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, ex; bit err, done; int waits;
        gap_en = 0;
        apb_xfer(1, 16'h0004, 32'h1234, rd, ex, err, waits, done);
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 16'h0004; PWDATA = 32'h0000_FFFF;
        clk_edge(0, 2'd0, '0);
        PENABLE = 1;
        #2 HRESET = 1;
        #1;
        vectors++; if (PREADY !== 1'b0) begin miscompares++; $display("FAIL rstmid_pready: got %b exp 0", PREADY); end
        @(posedge HCLK);
        #1 HRESET = 0; PSEL = 0; PENABLE = 0;
        m_reset();
        vectors++; if (PREADY !== 1'b0 || PSLVERR !== 1'b0) begin miscompares++; $display("FAIL rstmid_idle: pready %b pslverr %b exp 0 0", PREADY, PSLVERR); end
        apb_xfer(0, 16'h0004, '0, rd, ex, err, waits, done);
        vectors++; if (rd !== 32'h0 || waits !== WS) begin miscompares++; $display("FAIL rstmid_reload: got %h waits %0d exp 0 %0d", rd, waits, WS); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, ex, d; bit err, done, wr; int waits;
        logic [1:0] r; logic [15:0] a;
        gap_en = 1;
        for (int i = 0; i < 80; i++) begin
            r = 2'($urandom);
            wr = 1'($urandom);
            case (r)
                2'd0:    d = {16'h0, 8'($urandom_range(0, 2)), 5'h0, 3'($urandom)};
                2'd3:    d = 32'($urandom_range(0, 1));
                default: d = 32'($urandom_range(0, 6));
            endcase
            a = ($urandom_range(0, 9) == 0) ? {12'($urandom_range(1, 4095)), r, 2'b00} : {12'h0, r, 2'b00};
            apb_xfer(wr, a, d, rd, ex, err, waits, done);
            vectors++;
            if (rd !== ex || err !== (a[15:4] != 12'h0) || waits !== WS) begin
                miscompares++;
                $display("FAIL b2b%0d addr=%h wr=%b: data %h err %b waits %0d exp %h %b %0d", i, a, wr, rd, err, waits, ex, (a[15:4] != 12'h0), WS);
            end
            vectors++;
            if (IRQ !== (m_intstat & m_irqen)) begin miscompares++; $display("FAIL b2b_irq%0d: got %b exp %b", i, IRQ, m_intstat & m_irqen); end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_wait_states();
        test_periodic();
        test_oneshot();
        test_slverr();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
